// File: rtl/fetch_aligner.sv
// fetch_aligner
//   Instruction fetch aligner for an RV32IMC front end. Reads aligned 32-bit
//   words from instruction memory, tracks a halfword-granular PC, keeps a
//   one-halfword carry buffer and hands one instruction at a time downstream.
//   Compressed instructions are delivered as {16'h0, c}; 32-bit instructions
//   may straddle a word boundary.
//
// Ports
//   clk, resetb                 clock, asynchronous active-low reset
//   imem_ready/imem_addr        word request (registered), word-aligned address
//   imem_valid/imem_rdata/      memory accepts request; data and response
//   imem_rresp                  (1 = OK, 0 = bus error) valid in that cycle
//   redirect/redirect_pc        branch/trap redirect, highest priority
//   ins_valid/ins_ready         instruction handshake
//   ins/ins_pc/ins_compressed/  delivered instruction, its address, 16-bit flag
//   ins_fault                   and bus-error flag
//
// State | meaning
//   IDLE  | single cycle after reset, then FETCH
//   FETCH | requesting a word, or evaluating the next step when no request is up
//   HOLD  | instruction presented, waiting for consume
module fetch_aligner #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetb,
  output logic        imem_ready,
  input  logic        imem_valid,
  output logic [31:0] imem_addr,
  input  logic        imem_rresp,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic        ins_compressed,
  output logic        ins_fault
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] buf_q, buf_d;
  logic        buf_v_q, buf_v_d;
  logic        imem_ready_q, imem_ready_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic        ins_valid_q, ins_valid_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] ins_pc_q, ins_pc_d;
  logic        ins_compressed_q, ins_compressed_d;
  logic        ins_fault_q, ins_fault_d;

  logic [31:0] pc_inc;

  // Word address needed for the instruction at p: the word holding p, or the
  // following word when the low half of a 32-bit instruction is already buffered.
  function automatic logic [31:0] req_addr(input logic [31:0] p, input logic bv);
    return (p & ~32'd3) + ((p[1] && bv) ? 32'd4 : 32'd0);
  endfunction

  assign pc_inc = pc_q + (ins_compressed_q ? 32'd2 : 32'd4);

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    buf_d            = buf_q;
    buf_v_d          = buf_v_q;
    imem_ready_d     = imem_ready_q;
    imem_addr_d      = imem_addr_q;
    ins_valid_d      = ins_valid_q;
    ins_d            = ins_q;
    ins_pc_d         = ins_pc_q;
    ins_compressed_d = ins_compressed_q;
    ins_fault_d      = ins_fault_q;

    if (redirect) begin
      // Any coinciding transfer or consume is dropped.
      state_d      = FETCH;
      pc_d         = redirect_pc & ~32'd1;
      buf_v_d      = 1'b0;
      ins_valid_d  = 1'b0;
      imem_ready_d = 1'b1;
      imem_addr_d  = redirect_pc & ~32'd3;
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = FETCH;
          imem_ready_d = 1'b1;
          imem_addr_d  = req_addr(pc_q, buf_v_q);
        end

        FETCH: begin
          if (!imem_ready_q) begin
            if (buf_v_q && pc_q[1] && (buf_q[1:0] != 2'b11)) begin
              ins_d            = {16'h0, buf_q};
              ins_pc_d         = pc_q;
              ins_compressed_d = 1'b1;
              ins_fault_d      = 1'b0;
              ins_valid_d      = 1'b1;
              buf_v_d          = 1'b0;
              state_d          = HOLD;
            end else begin
              imem_ready_d = 1'b1;
              imem_addr_d  = req_addr(pc_q, buf_v_q);
            end
          end else if (imem_valid) begin
            imem_ready_d = 1'b0;
            if (!imem_rresp) begin
              ins_d            = imem_rdata;
              ins_pc_d         = pc_q;
              ins_compressed_d = 1'b0;
              ins_fault_d      = 1'b1;
              ins_valid_d      = 1'b1;
              buf_v_d          = 1'b0;
              state_d          = HOLD;
            end else if (!pc_q[1]) begin
              ins_pc_d    = pc_q;
              ins_fault_d = 1'b0;
              ins_valid_d = 1'b1;
              state_d     = HOLD;
              if (imem_rdata[1:0] != 2'b11) begin
                ins_d            = {16'h0, imem_rdata[15:0]};
                ins_compressed_d = 1'b1;
                buf_d            = imem_rdata[31:16];
                buf_v_d          = 1'b1;
              end else begin
                ins_d            = imem_rdata;
                ins_compressed_d = 1'b0;
                buf_v_d          = 1'b0;
              end
            end else if (!buf_v_q) begin
              // Odd PC with nothing buffered: load the upper half, then re-evaluate.
              buf_d   = imem_rdata[31:16];
              buf_v_d = 1'b1;
            end else begin
              ins_d            = {imem_rdata[15:0], buf_q};
              ins_pc_d         = pc_q;
              ins_compressed_d = 1'b0;
              ins_fault_d      = 1'b0;
              ins_valid_d      = 1'b1;
              buf_d            = imem_rdata[31:16];
              buf_v_d          = 1'b1;
              state_d          = HOLD;
            end
          end
        end

        HOLD: begin
          if (ins_valid_q && ins_ready) begin
            pc_d = pc_inc;
            if (buf_v_q && pc_inc[1] && (buf_q[1:0] != 2'b11)) begin
              // Buffered compressed instruction goes out with no bubble.
              ins_d            = {16'h0, buf_q};
              ins_pc_d         = pc_inc;
              ins_compressed_d = 1'b1;
              ins_fault_d      = 1'b0;
              buf_v_d          = 1'b0;
            end else begin
              ins_valid_d  = 1'b0;
              state_d      = FETCH;
              imem_ready_d = 1'b0;
              imem_addr_d  = req_addr(pc_inc, buf_v_q);
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q          <= IDLE;
      pc_q             <= RESET_VEC & ~32'd1;
      buf_q            <= 16'h0;
      buf_v_q          <= 1'b0;
      imem_ready_q     <= 1'b0;
      imem_addr_q      <= RESET_VEC & ~32'd3;
      ins_valid_q      <= 1'b0;
      ins_q            <= 32'h0;
      ins_pc_q         <= 32'h0;
      ins_compressed_q <= 1'b0;
      ins_fault_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      buf_q            <= buf_d;
      buf_v_q          <= buf_v_d;
      imem_ready_q     <= imem_ready_d;
      imem_addr_q      <= imem_addr_d;
      ins_valid_q      <= ins_valid_d;
      ins_q            <= ins_d;
      ins_pc_q         <= ins_pc_d;
      ins_compressed_q <= ins_compressed_d;
      ins_fault_q      <= ins_fault_d;
    end
  end

  assign imem_ready     = imem_ready_q;
  assign imem_addr      = imem_addr_q;
  assign ins_valid      = ins_valid_q;
  assign ins            = ins_q;
  assign ins_pc         = ins_pc_q;
  assign ins_compressed = ins_compressed_q;
  assign ins_fault      = ins_fault_q;

endmodule

// File: tb/tb_fetch_aligner.sv
module tb_fetch_aligner;

  logic        clk = 1'b0;
  logic        resetb;
  logic        imem_ready;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_rresp;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_compressed;
  logic        ins_fault;

  always #5 clk = ~clk;

  fetch_aligner #(.RESET_VEC(32'h0000_0100)) dut (
    .clk(clk), .resetb(resetb),
    .imem_ready(imem_ready), .imem_valid(imem_valid), .imem_addr(imem_addr),
    .imem_rresp(imem_rresp), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins), .ins_pc(ins_pc),
    .ins_compressed(ins_compressed), .ins_fault(ins_fault)
  );

  // 0-wait memory model; bus error on the word at 0x300.
  logic [31:0] mem [0:255];
  logic        mem_en;
  assign imem_valid = mem_en;
  assign imem_rdata = mem[imem_addr[9:2]];
  assign imem_rresp = (imem_addr != 32'h0000_0300);

  int xfer_cnt = 0;
  always @(posedge clk) if (imem_ready && imem_valid) xfer_cnt <= xfer_cnt + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ins(input string name, output int cyc);
    cyc = 0;
    while (!ins_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!ins_valid) chk({name, "_timeout"}, ins_valid, 1);
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect    = 1'b1;
    redirect_pc = t;
    @(negedge clk);
    redirect    = 1'b0;
  endtask

  task automatic consume();
    ins_ready = 1'b1;
    @(negedge clk);
    ins_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_ins;
    logic [31:0] exp_pc;
    logic        exp_c;
    logic        exp_f;
    logic        chk_ins;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int x0;

    vecs[0] = '{32'h0000_0100, 32'h0050_0093, 32'h0000_0100, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{32'h0000_0000, 32'h0000_0085, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_0002, 32'h0000_0505, 32'h0000_0002, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_0202, 32'h0000_4505, 32'h0000_0202, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{32'h0000_0012, 32'h0050_0093, 32'h0000_0012, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{32'h0000_0010, 32'h0000_4501, 32'h0000_0010, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{32'h0000_0300, 32'h0000_0000, 32'h0000_0300, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{32'h0000_0104, 32'h0000_0013, 32'h0000_0104, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h00] = 32'h0505_0085;
    mem[8'h04] = 32'h0093_4501;
    mem[8'h05] = 32'h0000_0050;
    mem[8'h40] = 32'h0050_0093;
    mem[8'h41] = 32'h0000_0013;
    mem[8'h80] = 32'h4505_0013;
    mem[8'hFF] = 32'h0001_0013;

    resetb = 1'b0; mem_en = 1'b1; ins_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_imem_ready", imem_ready, 0);
    chk("rst_imem_addr", imem_addr, 32'h100);
    chk("rst_ins_valid", ins_valid, 0);
    chk("rst_ins", ins, 0);
    chk("rst_ins_pc", ins_pc, 0);
    chk("rst_ins_c", ins_compressed, 0);
    chk("rst_ins_fault", ins_fault, 0);

    // Reset fetch: IDLE one cycle, request rises next, ins one cycle after transfer.
    resetb = 1'b1;
    chk("idle_ready_low", imem_ready, 0);
    @(negedge clk);
    chk("first_ready", imem_ready, 1);
    chk("first_addr", imem_addr, 32'h100);
    wait_ins("first", cyc);
    chk("first_latency", cyc, 1);
    chk("first_ins", ins, 32'h0050_0093);
    chk("first_pc", ins_pc, 32'h100);
    chk("first_c", ins_compressed, 0);
    consume();
    chk("first_cons_valid", ins_valid, 0);
    chk("first_cons_addr", imem_addr, 32'h104);
    chk("first_cons_ready", imem_ready, 0);
    wait_ins("second", cyc);
    chk("stream_gap", cyc, 2);
    chk("second_ins", ins, 32'h0000_0013);
    chk("second_pc", ins_pc, 32'h104);

    // Table: redirect (possibly while HOLD with ins_ready low) and first delivered instruction.
    for (int i = 0; i < 8; i++) begin
      do_redirect(vecs[i].target);
      chk($sformatf("v%0d_rd_valid", i), ins_valid, 0);
      chk($sformatf("v%0d_rd_addr", i), imem_addr, vecs[i].target & ~32'd3);
      wait_ins($sformatf("v%0d", i), cyc);
      if (vecs[i].chk_ins) chk($sformatf("v%0d_ins", i), ins, vecs[i].exp_ins);
      chk($sformatf("v%0d_pc", i), ins_pc, vecs[i].exp_pc);
      chk($sformatf("v%0d_c", i), ins_compressed, vecs[i].exp_c);
      chk($sformatf("v%0d_fault", i), ins_fault, vecs[i].exp_f);
    end

    // Two compressed in one word: single transfer, back-to-back delivery.
    do_redirect(32'h0);
    x0 = xfer_cnt;
    wait_ins("pair", cyc);
    chk("pair0_ins", ins, 32'h85);
    chk("pair0_pc", ins_pc, 32'h0);
    ins_ready = 1'b1;
    @(negedge clk);
    chk("pair1_valid", ins_valid, 1);
    chk("pair1_ins", ins, 32'h505);
    chk("pair1_pc", ins_pc, 32'h2);
    chk("pair1_c", ins_compressed, 1);
    @(negedge clk);
    ins_ready = 1'b0;
    chk("pair_after_valid", ins_valid, 0);
    chk("pair_after_addr", imem_addr, 32'h4);
    chk("pair_xfers", xfer_cnt - x0, 1);

    // Compressed then straddling 32-bit, then buffered zero halfword with no bubble.
    do_redirect(32'h10);
    wait_ins("str0", cyc);
    chk("str0_ins", ins, 32'h4501);
    consume();
    wait_ins("str1", cyc);
    chk("str1_ins", ins, 32'h0050_0093);
    chk("str1_pc", ins_pc, 32'h12);
    chk("str1_c", ins_compressed, 0);
    consume();
    chk("str2_valid", ins_valid, 1);
    chk("str2_ins", ins, 32'h0);
    chk("str2_pc", ins_pc, 32'h16);
    chk("str2_c", ins_compressed, 1);

    // Redirect while a transfer is pending and coincides with it.
    mem_en = 1'b0;
    do_redirect(32'h100);
    chk("pend_ready", imem_ready, 1);
    @(negedge clk);
    chk("pend_stable_ready", imem_ready, 1);
    chk("pend_stable_addr", imem_addr, 32'h100);
    mem_en = 1'b1;
    do_redirect(32'h202);
    chk("pend_rd_valid", ins_valid, 0);
    chk("pend_rd_addr", imem_addr, 32'h200);
    wait_ins("pend", cyc);
    chk("pend_ins", ins, 32'h4505);
    chk("pend_pc", ins_pc, 32'h202);

    // Bus error: request stays down while held; consume advances by 4.
    do_redirect(32'h300);
    wait_ins("flt", cyc);
    chk("flt_fault", ins_fault, 1);
    chk("flt_c", ins_compressed, 0);
    @(negedge clk);
    chk("flt_hold_valid", ins_valid, 1);
    chk("flt_hold_ready", imem_ready, 0);
    consume();
    chk("flt_cons_valid", ins_valid, 0);
    chk("flt_cons_addr", imem_addr, 32'h304);

    // PC wrap at the top of the address space.
    do_redirect(32'hFFFF_FFFE);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    wait_ins("wrap", cyc);
    chk("wrap_ins", ins, 32'h1);
    chk("wrap_pc", ins_pc, 32'hFFFF_FFFE);
    consume();
    chk("wrap_cons_addr", imem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
